// File: rtl/pc_pkg.sv
// Shared types and helpers for the SAP-2 program counter with return-address stack.
// Command decode honours the optional relative-branch build macro PC_REL_BRANCH_EN
// only at the top level; this package is build-independent.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_NOP,
        PC_INC,
        PC_LOAD,
        PC_CALL,
        PC_RET,
        PC_REL,
        PC_CONFLICT
    } pc_op_t;

    // Stack pointer must be able to represent DEPTH itself (the full state).
    function automatic int sp_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Only one command executes per edge: Call > Ret > Rel > Load > INC > hold,
    // with Call and Ret together treated as a conflict rather than either command.
    function automatic pc_op_t decode_op(
        input logic call,
        input logic ret,
        input logic rel,
        input logic load,
        input logic inc
    );
        pc_op_t op;
        if (call && ret) begin
            op = PC_CONFLICT;
        end else if (call) begin
            op = PC_CALL;
        end else if (ret) begin
            op = PC_RET;
        end else if (rel) begin
            op = PC_REL;
        end else if (load) begin
            op = PC_LOAD;
        end else if (inc) begin
            op = PC_INC;
        end else begin
            op = PC_NOP;
        end
        return op;
    endfunction

endpackage

// File: rtl/return_stack.sv
// DEPTH x WIDTH LIFO holding return addresses for CALL/RET.
// Push and pop are ignored when full / empty respectively; the caller reports errors.
// Contents are not reset, only the stack pointer.
module return_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             inCLK,
    input  logic             inRST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty
);

    localparam int SPW = sp_width(DEPTH);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if ((DEPTH < 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("return_stack: DEPTH must be a power of two and at least 1");
    end

    logic [SPW-1:0]   sp;
    logic [SPW-1:0]   sp_dec;
    logic [WIDTH-1:0] mem [DEPTH];

    assign sp_dec   = sp - SPW'(1);
    assign full     = (sp == SPW'(DEPTH));
    assign empty    = (sp == '0);
    assign top_data = mem[sp_dec[AW-1:0]];

    // Stack pointer: push has precedence, though the top level never requests both.
    always_ff @(posedge inCLK) begin
        if (!inRST) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp_dec;
        end
    end

    // Entry storage; written at the current pointer on an accepted push.
    always_ff @(posedge inCLK) begin
        if (inRST && push && !full) begin
            mem[sp[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// SAP-2 program counter: increment, load, CALL/RET through a hardware return stack,
// sticky stack-error flag, wrap pulse, tri-state W-bus driver and direct MAR feed.
// Build macro PC_REL_BRANCH_EN enables the PC-relative branch on inRel; when it is
// undefined inRel is ignored and no adder is generated for it.
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               DEPTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             inCLK,
    input  logic             inRST,
    input  logic             inINC,
    input  logic             inLoad,
    input  logic             inCall,
    input  logic             inRet,
    input  logic             inRel,
    input  logic [WIDTH-1:0] inData,
    input  logic             inEnableOut,
    output logic [WIDTH-1:0] outQP,
    output tri   [WIDTH-1:0] tWbus,
    output logic             outStackEmpty,
    output logic             outStackFull,
    output logic             outStackErr,
    output logic             outWrap
);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] top_data;
    logic             rel_req;
    logic             push;
    logic             pop;
    logic             stack_full;
    logic             stack_empty;
    logic             err;
    logic             wrap;
    pc_op_t           op;

`ifdef PC_REL_BRANCH_EN
    assign rel_req = inRel;
`else
    logic unused_rel;
    assign unused_rel = inRel;
    assign rel_req    = 1'b0;
`endif

    // Resolve the single command that executes this edge.
    always_comb begin
        op = decode_op(inCall, inRet, rel_req, inLoad, inINC);
    end

    assign push = (op == PC_CALL) && !stack_full;
    assign pop  = (op == PC_RET) && !stack_empty;

    return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_return_stack (
        .inCLK     (inCLK),
        .inRST     (inRST),
        .push      (push),
        .pop       (pop),
        .push_data (pc),
        .top_data  (top_data),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    // PC register, sticky error flag and one-cycle wrap pulse.
    always_ff @(posedge inCLK) begin
        if (!inRST) begin
            pc   <= RESET_VECTOR;
            err  <= 1'b0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (op)
                PC_CONFLICT: begin
                    err <= 1'b1;
                end
                PC_CALL: begin
                    if (stack_full) begin
                        err <= 1'b1;
                    end else begin
                        pc <= inData;
                    end
                end
                PC_RET: begin
                    if (stack_empty) begin
                        err <= 1'b1;
                    end else begin
                        pc <= top_data;
                    end
                end
`ifdef PC_REL_BRANCH_EN
                PC_REL: begin
                    pc <= pc + inData;
                end
`endif
                PC_LOAD: begin
                    pc <= inData;
                end
                PC_INC: begin
                    pc   <= pc + WIDTH'(1);
                    wrap <= &pc;
                end
                default: begin
                end
            endcase
        end
    end

    assign outQP         = pc;
    assign tWbus         = inEnableOut ? pc : {WIDTH{1'bz}};
    assign outStackEmpty = stack_empty;
    assign outStackFull  = stack_full;
    assign outStackErr   = err;
    assign outWrap       = wrap;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack (WIDTH=16, DEPTH=4, RESET_VECTOR=0x0100).
// Expected state is queued when each command is driven and checked after the edge.
// The W bus is observed through a pulled-up net, so a released bus reads all-ones.
module tb_program_counter_stack;

    localparam int W = 16;

`ifdef PC_REL_BRANCH_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] pc;
        logic         empty;
        logic         full;
        logic         err;
        logic         wrap;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         inc = 1'b0;
    logic         load = 1'b0;
    logic         call = 1'b0;
    logic         ret = 1'b0;
    logic         rel = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] data = '0;
    logic [W-1:0] qp;
    tri1  [W-1:0] w_bus;
    logic         empty;
    logic         full;
    logic         err;
    logic         wrap;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_mis = 0;

    program_counter_stack #(
        .WIDTH        (W),
        .DEPTH        (4),
        .RESET_VECTOR (16'h0100)
    ) dut (
        .inCLK         (clk),
        .inRST         (rst),
        .inINC         (inc),
        .inLoad        (load),
        .inCall        (call),
        .inRet         (ret),
        .inRel         (rel),
        .inData        (data),
        .inEnableOut   (en),
        .outQP         (qp),
        .tWbus         (w_bus),
        .outStackEmpty (empty),
        .outStackFull  (full),
        .outStackErr   (err),
        .outWrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic c, input logic rt,
                        input logic rl, input logic ld, input logic ic, input logic [W-1:0] d,
                        input logic [W-1:0] epc, input logic ee, input logic ef,
                        input logic er, input logic ew);
        exp_t  e;
        exp_t  got;
        string t;
        rst  = r;
        call = c;
        ret  = rt;
        rel  = rl;
        load = ld;
        inc  = ic;
        data = d;
        e.pc    = epc;
        e.empty = ee;
        e.full  = ef;
        e.err   = er;
        e.wrap  = ew;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        t   = tag_q.pop_front();
        chk({t, ".pc"},    qp,            got.pc);
        chk({t, ".empty"}, W'(empty),     W'(got.empty));
        chk({t, ".full"},  W'(full),      W'(got.full));
        chk({t, ".err"},   W'(err),       W'(got.err));
        chk({t, ".wrap"},  W'(wrap),      W'(got.wrap));
    endtask

    initial begin
        // Reset overrides a simultaneous Call.
        step("rst_over_call", 0, 1, 0, 0, 0, 0, 16'h5555, 16'h0100, 1, 0, 0, 0);
        chk("bus_released_rst", w_bus, 16'hFFFF);

        step("inc1", 1, 0, 0, 0, 0, 1, 16'h0000, 16'h0101, 1, 0, 0, 0);
        step("inc2", 1, 0, 0, 0, 0, 1, 16'h0000, 16'h0102, 1, 0, 0, 0);
        step("inc3", 1, 0, 0, 0, 0, 1, 16'h0000, 16'h0103, 1, 0, 0, 0);
        inc = 1'b0;
        chk("bus_released", w_bus, 16'hFFFF);
        en = 1'b1;
        #1;
        chk("bus_driven", w_bus, 16'h0103);
        en = 1'b0;
        #1;
        chk("bus_released_again", w_bus, 16'hFFFF);

        // Wrap pulse lasts exactly one cycle.
        step("load_ffff", 1, 0, 0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 1, 0, 0, 0);
        step("inc_wrap",  1, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 1, 0, 0, 1);
        step("hold",      1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0);

        // Nested call/return.
        step("load_0010", 1, 0, 0, 0, 1, 0, 16'h0010, 16'h0010, 1, 0, 0, 0);
        step("call_2000", 1, 1, 0, 0, 0, 0, 16'h2000, 16'h2000, 0, 0, 0, 0);
        step("call_3000", 1, 1, 0, 0, 0, 0, 16'h3000, 16'h3000, 0, 0, 0, 0);
        step("ret_1",     1, 0, 1, 0, 0, 0, 16'h0000, 16'h2000, 0, 0, 0, 0);
        step("ret_2",     1, 0, 1, 0, 0, 0, 16'h0000, 16'h0010, 1, 0, 0, 0);

        step("load_over_inc", 1, 0, 0, 0, 1, 1, 16'h1234, 16'h1234, 1, 0, 0, 0);

        // Overflow: fifth call is rejected.
        step("push_1", 1, 1, 0, 0, 0, 0, 16'h1000, 16'h1000, 0, 0, 0, 0);
        step("push_2", 1, 1, 0, 0, 0, 0, 16'h2000, 16'h2000, 0, 0, 0, 0);
        step("push_3", 1, 1, 0, 0, 0, 0, 16'h3000, 16'h3000, 0, 0, 0, 0);
        step("push_4", 1, 1, 0, 0, 0, 0, 16'h4000, 16'h4000, 0, 1, 0, 0);
        step("push_5_full", 1, 1, 0, 0, 0, 0, 16'h5000, 16'h4000, 0, 1, 1, 0);
        step("pop_after_ovf", 1, 0, 1, 0, 0, 0, 16'h0000, 16'h3000, 0, 0, 1, 0);

        // Conflict leaves PC and stack pointer alone.
        step("conflict", 1, 1, 1, 0, 0, 0, 16'h7777, 16'h3000, 0, 0, 1, 0);
        step("pop_a", 1, 0, 1, 0, 0, 0, 16'h0000, 16'h2000, 0, 0, 1, 0);
        step("pop_b", 1, 0, 1, 0, 0, 0, 16'h0000, 16'h1000, 0, 0, 1, 0);
        step("pop_c", 1, 0, 1, 0, 0, 0, 16'h0000, 16'h1234, 1, 0, 1, 0);

        // Reset overrides Ret and clears the sticky error; then underflow.
        step("rst_over_ret", 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0100, 1, 0, 0, 0);
        step("ret_empty",    1, 0, 1, 0, 0, 0, 16'h0000, 16'h0100, 1, 0, 1, 0);
        step("rst_2",        0, 0, 0, 0, 0, 0, 16'h0000, 16'h0100, 1, 0, 0, 0);
        step("conflict_fresh", 1, 1, 1, 0, 0, 0, 16'h2222, 16'h0100, 1, 0, 1, 0);
        step("rst_3",        0, 0, 0, 0, 0, 0, 16'h0000, 16'h0100, 1, 0, 0, 0);

        // Relative branch, or its absence in the default build.
        step("load_0050", 1, 0, 0, 0, 1, 0, 16'h0050, 16'h0050, 1, 0, 0, 0);
        step("rel_neg",   1, 0, 0, 1, 0, 0, 16'hFFF0,
             REL ? 16'h0040 : 16'h0050, 1, 0, 0, 0);
        step("rel_over_load", 1, 0, 0, 1, 1, 0, 16'h0008,
             REL ? 16'h0048 : 16'h0008, 1, 0, 0, 0);
        step("rel_wrap", 1, 0, 0, 1, 0, 0, 16'hFFF0,
             REL ? 16'h0038 : 16'h0008, 1, 0, 0, 0);
        step("call_over_all", 1, 1, 0, 1, 1, 1, 16'h6000, 16'h6000, 0, 0, 0, 0);
        step("ret_back", 1, 0, 1, 0, 0, 0, 16'h0000,
             REL ? 16'h0038 : 16'h0008, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
- Parametrised next-generation program counter for the SAP-2 datapath.
- Adds the following over a plain counter:
  - configurable width
  - synchronous load
  - a hardware return-address stack for CALL/RET
  - sticky stack-error flag
  - wrap indication
- Drives the shared W bus through tri-state outputs, and feeds the memory address register via a direct output.

Parameters:
- WIDTH, 16, counter/address width in bits.
- DEPTH, 4, return-stack entries; must be ≥1 and a power of two.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- inCLK  input  1  clock; all state changes on rising edge.
- inRST  input  1  synchronous reset, active-low.
- inINC  input  1  increment PC by 1.
- inLoad  input  1  load PC from inData (jump).
- inCall  input  1  push PC, then load PC from inData.
- inRet  input  1  pop top of stack into PC.
- inRel  input  1  relative branch; active only with PC_REL_BRANCH_EN.
- inData  input  WIDTH  jump target or relative offset.
- inEnableOut  input  1  drive PC onto tWbus.
- outQP  output  WIDTH  current PC, always driven.
- tWbus  output (tri)  WIDTH  PC when inEnableOut=1, else high-Z.
- outStackEmpty  output  1  stack holds 0 entries.
- outStackFull  output  1  stack holds DEPTH entries.
- outStackErr  output  1  sticky overflow/underflow/conflict flag.
- outWrap  output  1  one-cycle pulse when an increment wraps all-ones to 0.

Behaviour:
- Reset (inRST=0 at a rising edge):
  - PC=RESET_VECTOR, stack pointer=0, outStackErr=0, outWrap=0.
  - Stack contents are don't-care.
  - Reset overrides every command in the same cycle, including mid-sequence CALL/RET.
- Command priority, evaluated each edge when inRST=1: Call > Ret > Rel > Load > INC > hold.
  - Only the highest-priority asserted command executes.
  - outWrap is a registered pulse, so it is asserted in the cycle after the wrapping edge only.
- Conflict: inCall=1 and inRet=1 together is a conflict.
  - No state change, except outStackErr←1.
- INC:
  - PC←PC+1 modulo 2^WIDTH.
  - If PC was all-ones, outWrap=1 for the following cycle.
  - outWrap is 0 in all other cycles.
- Load: PC←inData.
- Call when not full:
  - stack[sp]←PC, sp←sp+1, PC←inData, all on the same edge.
  - The pushed value is the PC at the edge; the controller is responsible for having advanced the PC past the operand.
- Call when full: no push, PC unchanged, outStackErr←1.
- Ret when not empty: sp←sp−1, PC←stack[sp−1].
- Ret when empty: PC unchanged, outStackErr←1.
- Status flags:
  - outStackEmpty = (sp==0).
  - outStackFull = (sp==DEPTH).
  - Both are combinational from the registered sp.
  - sp is log2(DEPTH)+1 bits wide.
- outStackErr clears only on reset.
- Latency:
  - outQP/tWbus reflect the new PC in the cycle after the edge.
  - tWbus enable is purely combinational on inEnableOut, with no register delay.
- A stack push and pop never occur on the same edge.

Optional Feature:
- Macro: PC_REL_BRANCH_EN.
- Defined:
  - inRel=1 (when not pre-empted by Call/Ret) sets PC←PC+inData.
  - inData is treated as two's-complement WIDTH-bit; the result wraps modulo 2^WIDTH.
  - Wrap does not pulse outWrap.
- Undefined:
  - inRel is ignored; no logic is generated.
  - Priority falls through to Load/INC exactly as if inRel=0.

Decomposition:
- Package pc_pkg holds:
  - the command enum pc_op_t: PC_NOP, PC_INC, PC_LOAD, PC_CALL, PC_RET, PC_REL, PC_CONFLICT
  - a function that encodes the priority from the raw command inputs
  - a clog2-based stack-pointer width helper
- Sub-module return_stack: DEPTH×WIDTH LIFO with push/pop/full/empty, and the same inCLK/inRST.
  - The PC top level owns only the PC register, priority decode, error flag, wrap pulse and bus drivers.

Test Plan:
- Reset then INC: WIDTH=16, RESET_VECTOR=0x0100, release reset, inINC for 3 cycles → outQP 0x0100, 0x0101, 0x0102, 0x0103; tWbus=Z while inEnableOut=0, 0x0103 when 1.
- Wrap: Load 0xFFFF, then INC → outQP=0x0000, outWrap=1 for one cycle, then 0.
- Nested call/return: PC=0x0010, Call 0x2000, Call 0x3000, Ret, Ret → PC 0x2000, 0x3000, 0x2000, 0x0010; outStackEmpty=1 at end, outStackErr=0.
- Overflow/underflow: DEPTH=4, five Calls → fifth leaves PC unchanged, outStackFull=1, outStackErr=1; reset, then Ret → PC=RESET_VECTOR, outStackErr=1.
- Conflict and priority:
  - Call+Ret together → PC and sp unchanged, outStackErr=1.
  - Load 0x1234 with INC → PC=0x1234.
- Relative branch (with PC_REL_BRANCH_EN): PC=0x0050, inRel with inData=0xFFF0 → PC=0x0040; without the macro, the same stimulus holds PC at 0x0050.
